alu_cmd_issuer: RTL and testbench

//  Initiator side of the 19-bit ALU instruction interface: {op[2:0], opA[7:0], opB[7:0]} in, 16-bit R out.

---
 rtl/alu_cmd_issuer_pkg.sv | 25 ++
 rtl/alu_result_fixup.sv | 34 +++
 rtl/alu_cmd_issuer.sv | 131 +++++++++++++
 tb/tb_alu_cmd_issuer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_cmd_issuer_pkg.sv
// Shared definitions for ALU instruction issuers: opcodes, instruction word layout, FSM states.
package alu_cmd_issuer_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;

    localparam int INST_W = 19;
    localparam int OP_MSB = 18;
    localparam int A_LSB  = 8;
    localparam int B_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_OR;
    endfunction

endpackage

// File: rtl/alu_result_fixup.sv
// Combinational cleanup of raw ALU results (stale upper byte on sub/and/or).
// Optional flag outputs are enabled by ISSUER_FLAGS_EN.
module alu_result_fixup
    import alu_cmd_issuer_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [15:0] alu_r,
    output logic [15:0] data
`ifdef ISSUER_FLAGS_EN
    ,
    output logic        zero,
    output logic        carry
`endif
);

    always_comb begin
        data = '0;
        case (op)
            OP_ADD:        data = alu_r;
            OP_SUB:        data = {8'h00, alu_r[7:0]};
            OP_MUL:        data = alu_r;
            OP_AND, OP_OR: data = {8'h00, alu_r[7:0]};
            default:       data = '0;
        endcase
    end

`ifdef ISSUER_FLAGS_EN
    always_comb begin
        zero  = (data == 16'h0000);
        carry = (op == OP_ADD) ? alu_r[8] : 1'b0;
    end
`endif

endmodule

// File: rtl/alu_cmd_issuer.sv
// Initiator for the 19-bit ALU instruction interface: one command in flight, fixed ALU latency.
// Define ISSUER_FLAGS_EN to add the rsp_zero/rsp_carry outputs.
module alu_cmd_issuer
    import alu_cmd_issuer_pkg::*;
#(
    parameter int TAG_W   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [7:0]        cmd_a,
    input  logic [7:0]        cmd_b,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic [INST_W-1:0] alu_inst,
    input  logic [15:0]       alu_r,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [15:0]       rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_err
`ifdef ISSUER_FLAGS_EN
    ,
    output logic              rsp_zero,
    output logic              rsp_carry
`endif
);

    state_t     state, state_d;
    logic [2:0] cnt;
    logic       accept;
    logic       load_inst;
    logic       capture;
    logic       err_resp;
    logic [15:0] fix_data;
`ifdef ISSUER_FLAGS_EN
    logic       fix_zero;
    logic       fix_carry;
`endif

    alu_result_fixup u_fixup (
        .op    (alu_inst[OP_MSB:OP_MSB-2]),
        .alu_r (alu_r),
        .data  (fix_data)
`ifdef ISSUER_FLAGS_EN
        ,
        .zero  (fix_zero),
        .carry (fix_carry)
`endif
    );

    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d   = state;
        load_inst = 1'b0;
        capture   = 1'b0;
        err_resp  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (op_legal(cmd_op)) begin
                        load_inst = 1'b1;
                        state_d   = WAIT;
                    end else begin
                        err_resp  = 1'b1;
                        state_d   = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt == 3'(ALU_LAT)) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Response fields load once per command and then hold, keeping them stable under back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_inst  <= '0;
            cnt       <= '0;
            rsp_data  <= '0;
            rsp_tag   <= '0;
            rsp_err   <= 1'b0;
`ifdef ISSUER_FLAGS_EN
            rsp_zero  <= 1'b0;
            rsp_carry <= 1'b0;
`endif
        end else begin
            if (accept) rsp_tag <= cmd_tag;
            if (load_inst) begin
                alu_inst <= {cmd_op, cmd_a, cmd_b};
                cnt      <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt + 3'd1;
            end
            if (capture) begin
                rsp_data  <= fix_data;
                rsp_err   <= 1'b0;
`ifdef ISSUER_FLAGS_EN
                rsp_zero  <= fix_zero;
                rsp_carry <= fix_carry;
`endif
            end else if (err_resp) begin
                rsp_data  <= '0;
                rsp_err   <= 1'b1;
`ifdef ISSUER_FLAGS_EN
                rsp_zero  <= 1'b0;
                rsp_carry <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer with a registered ALU model that leaves R[15:8] stale on and/or.
module tb_alu_cmd_issuer;
    import alu_cmd_issuer_pkg::*;

    localparam int TAG_W   = 4;
    localparam int ALU_LAT = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [7:0]        cmd_a;
    logic [7:0]        cmd_b;
    logic [TAG_W-1:0]  cmd_tag;
    logic [INST_W-1:0] alu_inst;
    logic [15:0]       alu_r;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [15:0]       rsp_data;
    logic [TAG_W-1:0]  rsp_tag;
    logic              rsp_err;
`ifdef ISSUER_FLAGS_EN
    logic              rsp_zero;
    logic              rsp_carry;
`endif

    alu_cmd_issuer #(.TAG_W(TAG_W), .ALU_LAT(ALU_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_tag   (cmd_tag),
        .alu_inst  (alu_inst),
        .alu_r     (alu_r),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_tag   (rsp_tag),
        .rsp_err   (rsp_err)
`ifdef ISSUER_FLAGS_EN
        ,
        .rsp_zero  (rsp_zero),
        .rsp_carry (rsp_carry)
`endif
    );

    always #5 clk = ~clk;

    // ALU model: ALU_LAT register stages; and/or keep the previous upper byte
    function automatic logic [15:0] alu_eval(input logic [18:0] inst, input logic [7:0] stale);
        logic [7:0] a;
        logic [7:0] b;
        a = inst[15:8];
        b = inst[7:0];
        case (inst[18:16])
            3'd0:    return {8'h00, a} + {8'h00, b};
            3'd1:    return {8'h00, a} - {8'h00, b};
            3'd2:    return {8'h00, a} * {8'h00, b};
            3'd3:    return {stale, a & b};
            3'd4:    return {stale, a | b};
            default: return 16'hDEAD;
        endcase
    endfunction

    logic [15:0] pipe [ALU_LAT];
    always @(posedge clk) begin
        pipe[0] <= alu_eval(alu_inst, alu_r[15:8]);
        for (int i = 1; i < ALU_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign alu_r = pipe[ALU_LAT-1];

    typedef struct {
        logic [15:0]      data;
        logic [TAG_W-1:0] tag;
        logic             err;
        logic             zero;
        logic             carry;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [18:0] last_inst = '0;
    time         t_acc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per response handshake
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_data", 32'(rsp_data), 32'(e.data));
                chk("rsp_tag",  32'(rsp_tag),  32'(e.tag));
                chk("rsp_err",  32'(rsp_err),  32'(e.err));
`ifdef ISSUER_FLAGS_EN
                chk("rsp_zero",  32'(rsp_zero),  32'(e.zero));
                chk("rsp_carry", 32'(rsp_carry), 32'(e.carry));
`endif
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [TAG_W-1:0] tag, input logic [15:0] exp_data,
                        input logic exp_err, input logic exp_carry);
        exp_t e;
        e.data  = exp_data;
        e.tag   = tag;
        e.err   = exp_err;
        e.zero  = !exp_err && (exp_data == 16'h0000);
        e.carry = exp_carry;
        sb.push_back(e);
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_tag   = tag;
        cmd_valid = 1'b1;
    endtask

    task automatic wait_accept(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                @(posedge clk);
                t_acc = $time;
                #1;
                cmd_valid = 1'b0;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rsp(input string name, input int exp_lat);
        int n;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                n = i;
                break;
            end
        end
        chk(name, 32'(n), 32'(exp_lat));
    endtask

    task automatic run(input string name, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [TAG_W-1:0] tag,
                       input logic [15:0] exp_data, input logic exp_err, input logic exp_carry);
        bit ok;
        send(op, a, b, tag, exp_data, exp_err, exp_carry);
        wait_accept(ok);
        if (!exp_err) last_inst = {op, a, b};
        chk({name, "_inst"}, 32'(alu_inst), 32'(last_inst));
        wait_rsp({name, "_lat"}, exp_err ? 1 : ALU_LAT + 2);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit  ok;
        time t_first;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_tag   = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu_inst",  32'(alu_inst),  32'd0);
        chk("rst_rsp_data",  32'(rsp_data),  32'd0);
        chk("rst_rsp_tag",   32'(rsp_tag),   32'd0);
        chk("rst_rsp_err",   32'(rsp_err),   32'd0);
`ifdef ISSUER_FLAGS_EN
        chk("rst_rsp_zero",  32'(rsp_zero),  32'd0);
        chk("rst_rsp_carry", 32'(rsp_carry), 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run("add_ff_01", OP_ADD, 8'hFF, 8'h01, 4'd3, 16'h0100, 1'b0, 1'b1);
        chk("add_inst_word", 32'(alu_inst), 32'h0FF01);
        t_first = t_acc;
        run("mul_ff_ff", OP_MUL, 8'hFF, 8'hFF, 4'd4, 16'hFE01, 1'b0, 1'b0);
        chk("throughput", 32'((t_acc - t_first) / 10), 32'(ALU_LAT + 3));
        run("and_f0_3c", OP_AND, 8'hF0, 8'h3C, 4'd9, 16'h0030, 1'b0, 1'b0);
        run("illegal_110", 3'b110, 8'h12, 8'h34, 4'd10, 16'h0000, 1'b1, 1'b0);
        run("illegal_111", 3'b111, 8'hAA, 8'h55, 4'd15, 16'h0000, 1'b1, 1'b0);
        run("sub_05_07", OP_SUB, 8'h05, 8'h07, 4'd11, 16'h00FE, 1'b0, 1'b0);
        run("sub_05_05", OP_SUB, 8'h05, 8'h05, 4'd12, 16'h0000, 1'b0, 1'b0);
        run("add_80_80", OP_ADD, 8'h80, 8'h80, 4'd13, 16'h0100, 1'b0, 1'b1);
        run("or_01_02",  OP_OR,  8'h01, 8'h02, 4'd14, 16'h0003, 1'b0, 1'b0);

        // Back-pressure: response held 5 cycles while a second command waits
        rsp_ready = 1'b0;
        send(OP_OR, 8'h0F, 8'hA0, 4'd5, 16'h00AF, 1'b0, 1'b0);
        wait_accept(ok);
        wait_rsp("stall_lat", ALU_LAT + 2);
        send(OP_ADD, 8'h10, 8'h20, 4'd6, 16'h0030, 1'b0, 1'b0);
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid",     32'(rsp_valid), 32'd1);
            chk("stall_data",      32'(rsp_data),  32'h00AF);
            chk("stall_tag",       32'(rsp_tag),   32'd5);
            chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rsp_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("post_rsp_inst_held", 32'(alu_inst),  32'h40FA0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("second_accept_inst", 32'(alu_inst),  32'h01020);
        chk("second_busy",        32'(cmd_ready), 32'd0);
        wait_rsp("second_lat", ALU_LAT + 2);
        @(posedge clk);
        #1;

        // Reset during WAIT discards the in-flight command
        send(OP_MUL, 8'h03, 8'h04, 4'd7, 16'h000C, 1'b0, 1'b0);
        wait_accept(ok);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_alu_inst",  32'(alu_inst),  32'd0);
        chk("mid_rst_rsp_data",  32'(rsp_data),  32'd0);
        chk("mid_rst_rsp_tag",   32'(rsp_tag),   32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        last_inst = '0;
        repeat (ALU_LAT + 4) @(posedge clk);
        #1;
        chk("no_stale_rsp", 32'(rsp_valid), 32'd0);
        run("after_rst_add", OP_ADD, 8'h01, 8'h02, 4'd1, 16'h0003, 1'b0, 1'b0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
